// File: rtl/mux4_rr_select_if.sv
// Handshake bundle between the round-robin select generator and its requesters/consumer.
// master = arbiter side, slave = requester/consumer side.
interface mux4_rr_select_if;
  logic [3:0] req_i;
  logic [1:0] sel_o;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] gnt_o;

  modport master (
    input  req_i,
    input  ready_i,
    output sel_o,
    output valid_o,
    output gnt_o
  );

  modport slave (
    output req_i,
    output ready_i,
    input  sel_o,
    input  valid_o,
    input  gnt_o
  );
endinterface

// File: rtl/mux4_rr_select.sv
// Four-input round-robin arbiter producing a registered, handshake-held select for a 4:1 mux.
// The select stays frozen from arbitration until the consumer accepts; the grant pulses on acceptance.
module mux4_rr_select #(
  parameter bit BackToBack = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mux4_rr_select_if.master   arb
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] sel_q,   sel_d;
  logic       valid_q, valid_d;

  logic [2:0] idle_pick;
  logic [2:0] b2b_pick;
  logic [3:0] sel_onehot;

  function automatic logic [3:0] onehot(input logic [1:0] s);
    logic [3:0] v;
    v = 4'b0001 << s;
    return v;
  endfunction

  // Result is {found, index}; scans start, start+1, ... with 2-bit wrap.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!r[2] && req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign sel_onehot = onehot(sel_q);
  assign idle_pick  = pick(arb.req_i, ptr_q);
  // The just-served requester is masked so it cannot take two consecutive back-to-back slots.
  assign b2b_pick   = pick(arb.req_i & ~sel_onehot, sel_q + 2'd1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (idle_pick[2]) begin
          sel_d   = idle_pick[1:0];
          valid_d = 1'b1;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (arb.ready_i) begin
          ptr_d = sel_q + 2'd1;
          if (BackToBack && b2b_pick[2]) begin
            sel_d = b2b_pick[1:0];
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign arb.sel_o   = sel_q;
  assign arb.valid_o = valid_q;
  assign arb.gnt_o   = sel_onehot & {4{valid_q & arb.ready_i}};

  a_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_q && !arb.ready_i) |=> (valid_q && (sel_q == $past(sel_q))));

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(arb.gnt_o));

endmodule

// File: tb/tb_mux4_rr_select.sv
// Directed bench for mux4_rr_select: instance A uses back-to-back re-arbitration, instance B inserts IDLE.
module tb_mux4_rr_select;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux4_rr_select_if ifa ();
  mux4_rr_select_if ifb ();

  mux4_rr_select #(.BackToBack(1'b1)) dut_a (.clk_i(clk), .rst_ni(rst_n), .arb(ifa));
  mux4_rr_select #(.BackToBack(1'b0)) dut_b (.clk_i(clk), .rst_ni(rst_n), .arb(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifa.req_i = '0; ifa.ready_i = 1'b0;
    ifb.req_i = '0; ifb.ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.req_i = '0; ifa.ready_i = 1'b0;
    ifb.req_i = '0; ifb.ready_i = 1'b0;
    #12;
    checks++;
    if (ifa.valid_o !== 1'b0 || ifa.sel_o !== 2'd0 || ifa.gnt_o !== 4'b0) begin
      failures++;
      $display("FAIL reset_init: valid=%b sel=%0d gnt=%b expected valid=0 sel=0 gnt=0000", ifa.valid_o, ifa.sel_o, ifa.gnt_o);
    end
    @(negedge clk); rst_n = 1'b1;
    ifa.req_i = 4'b0100;
    tick();
    checks++;
    if (ifa.valid_o !== 1'b1 || ifa.sel_o !== 2'd2) begin
      failures++;
      $display("FAIL reset_prelock: valid=%b sel=%0d expected valid=1 sel=2", ifa.valid_o, ifa.sel_o);
    end
    ifa.ready_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifa.valid_o !== 1'b0 || ifa.sel_o !== 2'd0 || ifa.gnt_o !== 4'b0) begin
      failures++;
      $display("FAIL reset_midlock: valid=%b sel=%0d gnt=%b expected valid=0 sel=0 gnt=0000", ifa.valid_o, ifa.sel_o, ifa.gnt_o);
    end
    ifa.req_i = '0; ifa.ready_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ifa.valid_o !== 1'b0 || ifa.gnt_o !== 4'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: valid=%b gnt=%b expected valid=0 gnt=0000", i, ifa.valid_o, ifa.gnt_o);
      end
    end
  endtask

  task automatic test_single_backpressure();
    apply_reset();
    ifa.req_i = 4'b0100; ifa.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ifa.valid_o !== 1'b1 || ifa.sel_o !== 2'd2 || ifa.gnt_o !== 4'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b sel=%0d gnt=%b expected valid=1 sel=2 gnt=0000", i, ifa.valid_o, ifa.sel_o, ifa.gnt_o);
      end
    end
    ifa.ready_i = 1'b1; ifa.req_i = 4'b0000;
    #1;
    checks++;
    if (ifa.gnt_o !== 4'b0100) begin
      failures++;
      $display("FAIL bp_grant: gnt=%b expected 0100", ifa.gnt_o);
    end
    tick();
    checks++;
    if (ifa.valid_o !== 1'b0 || ifa.gnt_o !== 4'b0) begin
      failures++;
      $display("FAIL bp_after: valid=%b gnt=%b expected valid=0 gnt=0000", ifa.valid_o, ifa.gnt_o);
    end
  endtask

  // Continues from test_single_backpressure, where the pointer was left at 3.
  task automatic test_wrap_skip();
    ifa.req_i = 4'b0011; ifa.ready_i = 1'b0;
    tick();
    checks++;
    if (ifa.valid_o !== 1'b1 || ifa.sel_o !== 2'd0) begin
      failures++;
      $display("FAIL wrap_first: valid=%b sel=%0d expected valid=1 sel=0", ifa.valid_o, ifa.sel_o);
    end
    ifa.ready_i = 1'b1;
    tick();
    checks++;
    if (ifa.valid_o !== 1'b1 || ifa.sel_o !== 2'd1 || ifa.gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_second: valid=%b sel=%0d gnt=%b expected valid=1 sel=1 gnt=0010", ifa.valid_o, ifa.sel_o, ifa.gnt_o);
    end
    ifa.req_i = 4'b0001;
    tick();
    checks++;
    if (ifa.valid_o !== 1'b1 || ifa.sel_o !== 2'd0) begin
      failures++;
      $display("FAIL wrap_serve0: valid=%b sel=%0d expected valid=1 sel=0", ifa.valid_o, ifa.sel_o);
    end
    ifa.req_i = 4'b0000;
    tick();
    ifa.req_i = 4'b1001; ifa.ready_i = 1'b0;
    tick();
    checks++;
    if (ifa.valid_o !== 1'b1 || ifa.sel_o !== 2'd3) begin
      failures++;
      $display("FAIL skip_ptr1: valid=%b sel=%0d expected valid=1 sel=3", ifa.valid_o, ifa.sel_o);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    ifa.req_i = 4'b1111; ifa.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifa.valid_o !== 1'b1 || ifa.sel_o !== exp_sel[i] || ifa.gnt_o !== exp_gnt[i]) begin
        failures++;
        $display("FAIL rotation[%0d]: valid=%b sel=%0d gnt=%b expected valid=1 sel=%0d gnt=%b",
                 i, ifa.valid_o, ifa.sel_o, ifa.gnt_o, exp_sel[i], exp_gnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back_exclusion();
    logic exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    ifa.req_i = 4'b0001; ifa.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ifa.valid_o !== exp_v[i] || ifa.gnt_o !== (exp_v[i] ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL b2b_single[%0d]: valid=%b gnt=%b expected valid=%b", i, ifa.valid_o, ifa.gnt_o, exp_v[i]);
      end
    end
  endtask

  task automatic test_idle_insertion();
    logic       exp_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] exp_s [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    apply_reset();
    ifb.req_i = 4'b1111; ifb.ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifb.valid_o !== exp_v[i] || ifb.sel_o !== exp_s[i] ||
          ifb.gnt_o !== (exp_v[i] ? (4'b0001 << exp_s[i]) : 4'b0000)) begin
        failures++;
        $display("FAIL idle_ins[%0d]: valid=%b sel=%0d gnt=%b expected valid=%b sel=%0d",
                 i, ifb.valid_o, ifb.sel_o, ifb.gnt_o, exp_v[i], exp_s[i]);
      end
    end
    ifb.req_i = '0; ifb.ready_i = 1'b0;
  endtask

  task automatic test_withdrawal();
    apply_reset();
    ifa.req_i = 4'b0010; ifa.ready_i = 1'b0;
    tick();
    ifa.req_i = 4'b0000;
    tick();
    checks++;
    if (ifa.valid_o !== 1'b1 || ifa.sel_o !== 2'd1 || ifa.gnt_o !== 4'b0) begin
      failures++;
      $display("FAIL withdraw_hold: valid=%b sel=%0d gnt=%b expected valid=1 sel=1 gnt=0000", ifa.valid_o, ifa.sel_o, ifa.gnt_o);
    end
    ifa.ready_i = 1'b1;
    #1;
    checks++;
    if (ifa.gnt_o !== 4'b0010) begin
      failures++;
      $display("FAIL withdraw_grant: gnt=%b expected 0010", ifa.gnt_o);
    end
    tick();
    checks++;
    if (ifa.valid_o !== 1'b0 || ifa.gnt_o !== 4'b0) begin
      failures++;
      $display("FAIL withdraw_after: valid=%b gnt=%b expected valid=0 gnt=0000", ifa.valid_o, ifa.gnt_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_backpressure();
    test_wrap_skip();
    test_rotation();
    test_back_to_back_exclusion();
    test_idle_insertion();
    test_withdrawal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_select.md
# mux4_rr_select

Four-requester round-robin arbiter that generates the registered 2-bit select for the downstream 4:1 mux merge cell (`s_i`) and a valid/ready handshake toward the consumer of the mux output. The select is held stable from arbitration until the downstream handshake completes. A one-hot grant pulse returns to the winning requester on that handshake. The block sits directly upstream of the mux and owns the fairness policy for its four data inputs.

## Interface

- `BackToBack`, default `1'b1`:
  - 1 = re-arbitrate in the handshake cycle itself, so a handshake can occur every cycle.
  - 0 = an IDLE cycle is inserted after every handshake.
- `clk_i` input 1: single clock, rising edge.
- `rst_ni` input 1: asynchronous, active-low reset.
- `req_i` input 4: request per mux data input; bit k requests `i_i[k]`.
- `sel_o` output 2: registered select; drives the mux `s_i`.
- `valid_o` output 1: selected mux data is valid downstream.
- `ready_i` input 1: downstream accepts the data this cycle.
- `gnt_o` output 4: one-hot, combinational. Equals `onehot(sel_o) & {4{valid_o & ready_i}}`.

## Operation

- State register: IDLE or LOCK. Pointer register `ptr` is 2 bits.
- Priority order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`. All arithmetic is mod 4; the 2-bit add wraps 3 -> 0.
- IDLE:
  - If `req_i != 0`, register `sel_o` = first set bit of `req_i` in priority order, set `valid_o` = 1, go to LOCK.
  - Otherwise stay in IDLE; `valid_o` stays 0 and `sel_o` holds its last value.
- LOCK without a handshake (`ready_i` = 0):
  - `sel_o` and `valid_o` are held.
  - Changes on `req_i`, including withdrawal by the winner, are ignored until the handshake.
- LOCK with a handshake (`ready_i` = 1):
  - `gnt_o[sel_o]` = 1 for that cycle.
  - `ptr` <= `sel_o + 1`.
- After the handshake, with `BackToBack` = 1:
  - Arbitrate on `req_i & ~onehot(sel_o)`, priority starting at `sel_o + 1`.
  - If that set is non-empty: register the new `sel_o`, `valid_o` stays 1, stay in LOCK.
  - If it is empty: `valid_o` <= 0, go to IDLE.
  - The just-served requester cannot win two consecutive back-to-back slots. It becomes eligible again from the next IDLE arbitration.
- After the handshake, with `BackToBack` = 0: `valid_o` <= 0 and go to IDLE unconditionally.
- `ready_i` is ignored while `valid_o` = 0. `gnt_o` is 0 whenever `valid_o` = 0.
- Reset (asynchronous, any cycle, including mid-LOCK):
  - State = IDLE, `ptr` = 0, `sel_o` = 0, `valid_o` = 0, `gnt_o` = 0.
  - A pending, un-handshaken transfer is dropped without a grant.

## Timing

- Arbitration latency: a request sampled at edge n (from IDLE) gives `valid_o` = 1 and a stable `sel_o` after edge n.
- `sel_o` changes only on the clock edge that enters LOCK or re-arbitrates. It never changes while `valid_o` = 1 and `ready_i` = 0, so the mux output is stable for the consumer.
- `gnt_o` has a combinational path from `ready_i`. There is no path from `req_i` to any output.
- Throughput:
  - `BackToBack` = 1: one handshake per cycle while at least two distinct requesters are active.
  - `BackToBack` = 0: one handshake per two cycles.
- Fairness: with all four requesters continuously active, the grant order is 0,1,2,3,0,… Every requester is served within 4 handshakes of asserting its request.

## Test plan

- Reset and idle:
  - Assert `rst_ni` = 0 mid-LOCK with `sel_o` = 2: `valid_o` = 0, `sel_o` = 0, `gnt_o` = 0 immediately.
  - After release with `req_i` = 0: `valid_o` stays 0.
- Single request with backpressure:
  - From reset drive `req_i` = 4'b0100 and `ready_i` = 0 for 3 cycles: `sel_o` = 2, `valid_o` = 1 one edge later, held for all 3 cycles.
  - Then `ready_i` = 1: `gnt_o` = 4'b0100 for exactly one cycle, `ptr` = 3.
- Round-robin rotation:
  - Drive `req_i` = 4'b1111 and `ready_i` = 1 continuously (`BackToBack` = 1): `sel_o` sequence is 0,1,2,3,0.
  - Exactly one `gnt_o` bit is set per cycle, in the same order.
- Wrap-around and skip:
  - Start from `ptr` = 3 and drive `req_i` = 4'b0011: winner is 0, then 1.
  - With `req_i` = 4'b1001 and `ptr` = 1: winner is 3.
- Back-to-back exclusion and IDLE insertion:
  - `BackToBack` = 1, `req_i` = 4'b0001 held with `ready_i` = 1: `valid_o` pattern is 1,0,1,0; `gnt_o[0]` pulses every other cycle.
  - `BackToBack` = 0, `req_i` = 4'b1111: `valid_o` alternates 1,0.
- Request withdrawal while locked: in LOCK with `sel_o` = 1, drop `req_i[1]` while `ready_i` = 0. Then `sel_o` stays 1 and `valid_o` stays 1, and the next `ready_i` = 1 gives `gnt_o` = 4'b0010.
